// File: rtl/laplacian_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laplacian_result_writer_pkg
// Description : Shared widths, FIFO entry layout, FSM state encoding and the
//               magnitude helper for the Laplacian result writer.
// Revision    : 1.0 - initial release
// ============================================================================
package laplacian_result_writer_pkg;

  localparam int PIX_W   = 8;    // output pixel width
  localparam int SUM_W   = 6;    // signed filter-sum width
  localparam int PIX_MAX = 255;  // saturation ceiling

  // A skip entry occupies one address slot but is never written to memory.
  typedef struct packed {
    logic             skip;
    logic [PIX_W-1:0] pix;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Absolute value of a two's-complement sum as an unsigned SUM_W value;
  // the most negative input maps to 2^(SUM_W-1), which still fits.
  function automatic logic [SUM_W-1:0] abs_sum(input logic [SUM_W-1:0] sum);
    return sum[SUM_W-1] ? SUM_W'(~sum + SUM_W'(1)) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/laplacian_result_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : writer_fifo
// Description : Synchronous FIFO, power-of-two depth (>= 2). A push while
//               full is accepted only if a pop happens in the same cycle.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               i_push/i_din - write request and data
//               i_pop        - remove head entry
//               o_full/o_empty/o_head - status and head entry
// Revision    : 1.0 - initial release
// ============================================================================
module writer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/laplacian_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : laplacian_result_writer
// Description : Converts signed Laplacian sums to saturated 8-bit edge
//               magnitudes, buffers them and writes them to image memory at
//               linear addresses; tracks frame completion and overflow.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - arm a new frame (ignored while busy)
//               in_valid, in_data   - upstream result strobe and sum
//               mem_ready           - memory accepts a write this cycle
//               mem_we/addr/wdata   - memory write request
//               busy, frame_done    - frame status
//               overflow            - sticky: a sample was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module laplacian_result_writer
  import laplacian_result_writer_pkg::*;
#(
  parameter int OUT_W      = 6,
  parameter int OUT_H      = 6,
  parameter int ADDR_W     = 6,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int TOTAL = OUT_W * OUT_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SC_W  = PIX_W + SHIFT;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_accept_cnt;
  logic [CNT_W-1:0] r_write_cnt;
  logic [CNT_W-1:0] r_skip_pend;
  logic             r_stg_valid;
  logic [PIX_W-1:0] r_stg_pix;
  logic             r_overflow;

  logic [SUM_W-1:0] w_mag;
  logic [SC_W-1:0]  w_scaled;
  logic [PIX_W-1:0] w_conv_pix;
  logic             w_start;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  fifo_entry_t      w_head;
  fifo_entry_t      w_din;
  logic             w_pop;
  logic             w_space;
  logic             w_push_skip;
  logic             w_push_pix;
  logic             w_drop;
  logic             w_last_write;

  // Conversion: |sum| << SHIFT, saturated to the pixel range.
  assign w_mag      = abs_sum(in_data);
  assign w_scaled   = SC_W'(w_mag) << SHIFT;
  assign w_conv_pix = (w_scaled > SC_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_scaled[PIX_W-1:0];

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_RUN) && in_valid && (r_accept_cnt != CNT_W'(TOTAL));

  // Skip entries pop immediately; real pixels wait for mem_ready.
  assign w_pop   = !w_empty && (w_head.skip || mem_ready);
  assign w_space = !w_full || w_pop;

  // Dropped pixels are remembered in r_skip_pend and re-enter the FIFO as
  // skip entries as soon as there is room, keeping address order intact.
  // While skips are pending they take the single push slot, so a pixel
  // arriving at that moment is dropped as well.
  assign w_push_skip = (r_skip_pend != '0) && w_space;
  assign w_drop      = r_stg_valid && ((r_skip_pend != '0) || !w_space);
  assign w_push_pix  = r_stg_valid && !w_drop;

  assign w_din.skip = w_push_skip;
  assign w_din.pix  = w_push_skip ? '0 : r_stg_pix;

  assign w_last_write = w_pop && (r_write_cnt == CNT_W'(TOTAL - 1));

  writer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_skip || w_push_pix),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last_write)                           w_state_nxt = ST_DONE;
        else if (r_accept_cnt == CNT_W'(TOTAL))     w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_last_write) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_accept_cnt <= '0;
      r_write_cnt  <= '0;
      r_skip_pend  <= '0;
      r_stg_valid  <= 1'b0;
      r_stg_pix    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_stg_valid <= w_accept;
      if (w_accept) r_stg_pix <= w_conv_pix;
      if (w_start) begin
        r_accept_cnt <= '0;
        r_write_cnt  <= '0;
        r_skip_pend  <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_accept) r_accept_cnt <= r_accept_cnt + CNT_W'(1);
        if (w_pop)    r_write_cnt  <= r_write_cnt + CNT_W'(1);
        r_skip_pend <= r_skip_pend + CNT_W'(w_drop) - CNT_W'(w_push_skip);
        if (w_drop)   r_overflow   <= 1'b1;
      end
    end
  end

  assign mem_we     = !w_empty && !w_head.skip;
  // Gated so the uninitialised FIFO storage never shows on the bus.
  assign mem_wdata  = mem_we ? w_head.pix : '0;
  assign mem_addr   = ADDR_W'(r_write_cnt);
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign frame_done = (r_state == ST_DONE);
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_laplacian_result_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_laplacian_result_writer
// Description : Scoreboard bench for laplacian_result_writer. Two instances
//               (gain shift 2 and 3) share all inputs; expected writes are
//               queued at stimulus time and popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laplacian_result_writer;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, mem_ready;
  logic [5:0] in_data;
  logic       mem_we, busy, frame_done, overflow;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we3, busy3, frame_done3, overflow3;
  logic [5:0] mem_addr3;
  logic [7:0] mem_wdata3;

  laplacian_result_writer #(.OUT_W(6), .OUT_H(6), .ADDR_W(6), .SHIFT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .frame_done(frame_done), .overflow(overflow));

  laplacian_result_writer #(.OUT_W(6), .OUT_H(6), .ADDR_W(6), .SHIFT(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .mem_ready(mem_ready), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .busy(busy3), .frame_done(frame_done3), .overflow(overflow3));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_addr = 0;
  int   fd_cnt = 0;
  int   cyc = 0;
  int   last_wr_cyc = -10;
  bit   hold_v = 1'b0;
  logic [5:0] hold_a;
  logic [7:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion: min(|d| * 2^sh, 255).
  function automatic logic [7:0] px(input logic [5:0] d, input int sh);
    int m;
    int s;
    m = d[5] ? (64 - int'(d)) : int'(d);
    s = m << sh;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (mem_we && mem_ready) begin
        n_vec++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write addr=%0d data=%0d", mem_addr, mem_wdata);
        end else begin
          e = q2.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            n_err++;
            $display("FAIL write_s2 actual addr=%0d data=%0d required addr=%0d data=%0d",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
        last_wr_cyc = cyc;
      end
      if (mem_we3 && mem_ready) begin
        n_vec++;
        if (q3.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write_s3 addr=%0d data=%0d", mem_addr3, mem_wdata3);
        end else begin
          e = q3.pop_front();
          if (mem_addr3 !== e.addr || mem_wdata3 !== e.data) begin
            n_err++;
            $display("FAIL write_s3 actual addr=%0d data=%0d required addr=%0d data=%0d",
                     mem_addr3, mem_wdata3, e.addr, e.data);
          end
        end
      end
      if (hold_v) begin
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== hold_a || mem_wdata !== hold_d) begin
          n_err++;
          $display("FAIL stall_hold actual we=%0d addr=%0d data=%0d required we=1 addr=%0d data=%0d",
                   mem_we, mem_addr, mem_wdata, hold_a, hold_d);
        end
      end
      hold_v = mem_we && !mem_ready;
      hold_a = mem_addr;
      hold_d = mem_wdata;
      if (frame_done) begin
        fd_cnt++;
        n_vec++;
        if (busy !== 1'b0 || cyc != last_wr_cyc + 1) begin
          n_err++;
          $display("FAIL frame_done_timing actual busy=%0d gap=%0d required busy=0 gap=1",
                   busy, cyc - last_wr_cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [5:0] d, input logic [7:0] e2, input logic [7:0] e3,
                          input bit wr, input bit acc);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    if (acc) begin
      if (wr) begin
        e.addr = 6'(exp_addr); e.data = e2; q2.push_back(e);
        e.data = e3; q3.push_back(e);
      end
      exp_addr++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [5:0] d, input bit wr, input bit acc);
    send_exp(d, px(d, 2), px(d, 3), wr, acc);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_frame_end();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("frame_end_timeout", int'(n < 400), 1);
    tick();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    int'(mem_we),     0);
    chk({tag, "_addr"},  int'(mem_addr),   0);
    chk({tag, "_wdata"}, int'(mem_wdata),  0);
    chk({tag, "_busy"},  int'(busy),       0);
    chk({tag, "_done"},  int'(frame_done), 0);
    chk({tag, "_ovf"},   int'(overflow),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_all_zero("reset");

    // Frame A: conversion sweep, latency, full frame, 37th sample ignored.
    do_start();
    send_exp(6'h20, 8'd128, 8'd255, 1'b1, 1'b1);   // -32
    chk("latency_n1_we", int'(mem_we), 0);
    tick();
    chk("latency_n2_we", int'(mem_we), 1);
    chk("latency_n2_addr", int'(mem_addr), 0);
    send_exp(6'h3F, 8'd4,   8'd8,   1'b1, 1'b1);   // -1
    send_exp(6'h00, 8'd0,   8'd0,   1'b1, 1'b1);   // 0
    send_exp(6'h07, 8'd28,  8'd56,  1'b1, 1'b1);   // 7
    send_exp(6'h1F, 8'd124, 8'd248, 1'b1, 1'b1);   // 31
    for (int i = 0; i < 31; i++) send(6'(i * 11 + 5), 1'b1, 1'b1);
    send(6'h15, 1'b0, 1'b0);                        // 37th: ignored
    wait_frame_end();
    chk("frameA_done_count", fd_cnt, 1);
    chk("frameA_overflow", int'(overflow), 0);

    // Frame B: backpressure, samples 5 and 6 dropped, addresses 4/5 skipped.
    do_start();
    send(6'h01, 1'b1, 1'b1);
    mem_ready = 1'b0;
    for (int k = 1; k < 6; k++) send(6'(k * 9 + 2), k < 4, 1'b1);
    tick();
    mem_ready = 1'b1;
    repeat (8) tick();
    chk("frameB_overflow_set", int'(overflow), 1);
    for (int i = 6; i < 36; i++) send(6'(i * 13 + 1), 1'b1, 1'b1);
    wait_frame_end();
    chk("frameB_done_count", fd_cnt, 2);
    chk("frameB_overflow_sticky", int'(overflow), 1);

    // Frame C: mem_ready toggling, stalled outputs must hold.
    do_start();
    chk("frameC_overflow_cleared", int'(overflow), 0);
    for (int i = 0; i < 36; i++) begin
      mem_ready = ~mem_ready;
      send(6'(i * 7 + 30), 1'b1, 1'b1);
      repeat (2) begin
        mem_ready = ~mem_ready;
        tick();
      end
    end
    mem_ready = 1'b1;
    wait_frame_end();
    chk("frameC_done_count", fd_cnt, 3);
    chk("frameC_overflow", int'(overflow), 0);

    // Frame D: reset after 10 writes with two writes still pending.
    do_start();
    for (int i = 0; i < 10; i++) send(6'(i * 5 + 40), 1'b1, 1'b1);
    repeat (3) tick();
    mem_ready = 1'b0;
    send(6'h2A, 1'b1, 1'b1);
    send(6'h0B, 1'b1, 1'b1);
    repeat (3) tick();
    chk("frameD_pending_we", int'(mem_we), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q2.delete();
    q3.delete();
    chk_all_zero("midreset");
    mem_ready = 1'b1;
    repeat (4) tick();
    chk("frameD_no_done", fd_cnt, 3);

    // Frame E: restart from address 0 after reset.
    do_start();
    chk("frameE_overflow", int'(overflow), 0);
    for (int i = 0; i < 36; i++) send(6'(i * 3 + 17), 1'b1, 1'b1);
    send(6'h3A, 1'b0, 1'b0);
    wait_frame_end();
    chk("frameE_done_count", fd_cnt, 4);
    chk("queue_s2_drained", q2.size(), 0);
    chk("queue_s3_drained", q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
